// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmit FIFO.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a byte FIFO in front of the shift register.
// Drives the board TX pin; frames go out LSB first, back to back while
// the FIFO holds data.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit time
// DATA  | eight data bits, shift[0] on the line
// STOP  | stop bit (high); chains straight into START if data is queued
module uart_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  uart_tx_if.slave                           in_if,
  output logic                               bit_out,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              bit_out_q, bit_out_d;

  logic push;
  logic pop;
  logic fifo_empty;
  logic fifo_full;
  logic baud_tick;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign baud_tick  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  assign in_if.data_ready = !fifo_full;
  assign push             = in_if.data_valid && !fifo_full;

  assign bit_out    = bit_out_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;

  // Frame sequencing: baud timing, bit index, shift register and pop request.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    baud_d    = baud_tick ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_mem_q[rd_ptr_q];
          bit_idx_d = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_tick) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        if (baud_tick) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_mem_q[rd_ptr_q];
            bit_idx_d = 3'd0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // Line level follows the current state; registered so the pin never glitches.
  always_comb begin
    case (state_q)
      START:   bit_out_d = 1'b0;
      DATA:    bit_out_d = shift_q[0];
      default: bit_out_d = 1'b1;
    endcase
  end

  // FIFO pointers and occupancy; push and pop in one cycle cancel out.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= in_if.data_in;
    end
  end

  // State registers; reset aborts any frame and drops queued bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      bit_out_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      bit_out_q <= bit_out_d;
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-serial 8N1 UART transmitter: the transmit end of the serial link whose receive end loads code into the workbench.
- Accepts bytes on a valid/ready handshake into an internal FIFO and shifts them out on `bit_out`, LSB first.
- Sits in the workbench next to the receiver and drives the board TX pin (RsTx).
- Used for debug/output traffic from the core's output map.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per serial bit (100 MHz / 9600 baud); must be >= 2.
- FIFO_DEPTH, 16, byte entries in the transmit FIFO; must be a power of two >= 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  FIFO can accept a byte; equals not-full.
- bit_out  output  1  serial line; idle high.
- busy  output  1  a frame is in progress or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of bytes queued, excluding the byte being shifted.

Behaviour:
- Reset values (the cycle after rst is sampled high):
  - bit_out=1, busy=0, fifo_count=0, data_ready=1.
  - FIFO pointers zeroed; state=IDLE; bit counter and baud counter zeroed.
  - Reset mid-frame aborts the frame immediately: bit_out returns high and queued bytes are discarded.
- Push:
  - Occurs when data_valid & data_ready at a posedge.
  - The byte is written at the write pointer and the write pointer increments, wrapping modulo FIFO_DEPTH.
  - data_ready is combinational !full (full means count==FIFO_DEPTH).
  - data_valid while full is ignored: no write, no error flag.
- Pop:
  - Occurs only when the FSM loads a byte (below); the read pointer increments with wrap.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - Pop never occurs while empty.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - bit_out=1.
  - If the FIFO is non-empty: pop into the shift register, clear the baud counter, and go to START.
- START:
  - bit_out=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - bit_out=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index.
  - After bit index 7 completes, go to STOP.
- STOP:
  - bit_out=1 for CLKS_PER_BIT cycles.
  - At the end: if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Latency:
  - A byte pushed into an empty, idle transmitter at edge t is visible in the FIFO after t.
  - It is popped at edge t+1; bit_out falls after edge t+2.
  - A frame is exactly 10*CLKS_PER_BIT cycles of line time.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit transitions occur only on the wrap.
- busy = (state!=IDLE) | (fifo_count!=0); combinational.
- bit_out is driven from a register (glitch-free).
- fifo_count increments or decrements by at most 1 per cycle and saturates nowhere, because push is blocked when full.
- Byte ordering: FIFO order is preserved; the frame order on the line equals the push order.

Test Plan:
1. CLKS_PER_BIT=4: push 0xA5 once while idle.
   - Required line: start 0, then bits 1,0,1,0,0,1,0,1, then stop 1.
   - Each level lasts exactly 4 cycles; the falling edge comes 2 cycles after the push.
   - busy returns 0 after 40 line cycles.
2. Push 0x00, 0xFF, 0x3C on consecutive cycles.
   - Three contiguous frames with no idle cycles between the stop bit and the next start bit.
   - Each frame decodes correctly via a reference UART RX model.
   - fifo_count peaks at 2.
3. FIFO_DEPTH=4: hold data_valid high with 8 distinct bytes.
   - data_ready falls once 4 bytes are queued beyond the byte in flight.
   - Bytes presented while data_ready=0 are not queued unless re-presented.
   - All accepted bytes are transmitted in order.
4. Assert rst in DATA state (bit index 3).
   - Next cycle: bit_out=1, busy=0, fifo_count=0.
   - No further low levels appear until a new push.
5. Same-cycle push and pop: while a frame is ending, with 1 byte queued, push a byte in the STOP final cycle.
   - fifo_count stays 1 across that edge.
   - Both bytes are transmitted in order.
6. Idle line check: no pushes for 1000 cycles after reset.
   - bit_out constantly 1, data_ready=1, busy=0.
